// File: rtl/clock_set_controller_if.sv
// clock_set_controller_if: button, live-time and load/display signals between the set controller and its peers
interface clock_set_controller_if;
  logic       mode;
  logic       increment;
  logic [7:0] cur_seconds;
  logic [7:0] cur_minutes;
  logic [7:0] cur_hours;
  logic       run_en;
  logic       load;
  logic [7:0] load_seconds;
  logic [7:0] load_minutes;
  logic [7:0] load_hours;
  logic [1:0] edit_field;
  modport master (
    output mode, increment, cur_seconds, cur_minutes, cur_hours,
    input  run_en, load, load_seconds, load_minutes, load_hours, edit_field
  );
  modport slave (
    input  mode, increment, cur_seconds, cur_minutes, cur_hours,
    output run_en, load, load_seconds, load_minutes, load_hours, edit_field
  );
endinterface

// File: rtl/clock_set_controller.sv
// clock_set_controller: edit FSM that freezes the timekeeper, edits shadow time and loads it back
module clock_set_controller #(
  parameter int unsigned CLOCK_FREQ   = 50000000,
  parameter int unsigned REPEAT_DELAY = CLOCK_FREQ / 2,
  parameter int unsigned REPEAT_RATE  = CLOCK_FREQ / 8,
  parameter int unsigned EDIT_TIMEOUT = CLOCK_FREQ * 10
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  clock_set_controller_if.slave  bus
);
  localparam logic [2:0] RUN = 3'd0, SET_HR = 3'd1, SET_MIN = 3'd2, SET_SEC = 3'd3, COMMIT = 3'd4;
  logic [2:0]  r_state;
  logic        r_mode_prev, r_inc_prev;
  logic [31:0] r_hold, r_idle;
  logic [7:0]  r_sec, r_min, r_hr;
  logic        r_run_en, r_load;
  logic [1:0]  r_field;
  logic        w_mode_edge, w_inc_edge, w_editing, w_repeat, w_bump, w_timeout;
  logic [2:0]  w_next;
  always_comb begin
    w_mode_edge = bus.mode & ~r_mode_prev;
    w_inc_edge  = bus.increment & ~r_inc_prev;
    w_editing   = (r_state == SET_HR) | (r_state == SET_MIN) | (r_state == SET_SEC);
    w_repeat    = w_editing & bus.increment & ~w_inc_edge & (r_hold == REPEAT_DELAY);
    w_bump      = w_editing & ~w_mode_edge & (w_inc_edge | w_repeat);
    w_timeout   = w_editing & ~w_mode_edge & ~w_bump & (r_idle == EDIT_TIMEOUT - 1);
    w_next      = (r_state == RUN)    ? (w_mode_edge ? SET_HR : RUN) :
                  (r_state == COMMIT) ? RUN :
                  w_mode_edge         ? ((r_state == SET_SEC) ? COMMIT : r_state + 3'd1) :
                  w_timeout           ? RUN : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= RUN;
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
      r_hold      <= '0;
      r_idle      <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hr        <= '0;
      r_run_en    <= 1'b1;
      r_load      <= 1'b0;
      r_field     <= 2'd0;
    end else begin
      r_state     <= w_next;
      r_mode_prev <= bus.mode;
      r_inc_prev  <= bus.increment;
      r_run_en    <= (w_next == RUN);
      r_load      <= (w_next == COMMIT);
      r_field     <= (w_next == SET_HR) ? 2'd1 : (w_next == SET_MIN) ? 2'd2 : (w_next == SET_SEC) ? 2'd3 : 2'd0;
      // hold counter only runs after a real edge, so a press carried in from RUN never repeats
      if (!w_editing || w_mode_edge || !bus.increment) r_hold <= '0;
      else if (w_inc_edge) r_hold <= 32'd1;
      else if (w_repeat) r_hold <= REPEAT_DELAY - REPEAT_RATE + 1;
      else if (r_hold != '0) r_hold <= r_hold + 32'd1;
      r_idle <= (!w_editing || w_mode_edge || w_bump) ? '0 : r_idle + 32'd1;
      if (r_state == RUN && w_mode_edge) begin
        r_sec <= bus.cur_seconds;
        r_min <= bus.cur_minutes;
        r_hr  <= bus.cur_hours;
      end else if (w_bump) begin
        if (r_state == SET_HR)  r_hr  <= (r_hr  >= 8'd23) ? 8'd0 : r_hr  + 8'd1;
        if (r_state == SET_MIN) r_min <= (r_min >= 8'd59) ? 8'd0 : r_min + 8'd1;
        if (r_state == SET_SEC) r_sec <= (r_sec >= 8'd59) ? 8'd0 : r_sec + 8'd1;
      end
    end
  end
  assign bus.run_en       = r_run_en;
  assign bus.load         = r_load;
  assign bus.load_seconds = r_sec;
  assign bus.load_minutes = r_min;
  assign bus.load_hours   = r_hr;
  assign bus.edit_field   = r_field;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed scenarios with hand-computed expectations for the set controller
module tb_clock_set_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   load_cnt = 0;
  int   saved;
  clock_set_controller_if bus();
  clock_set_controller #(.REPEAT_DELAY(8), .REPEAT_RATE(2), .EDIT_TIMEOUT(50)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.load === 1'b1) load_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press_mode();
    bus.mode = 1'b1;
    tick();
    bus.mode = 1'b0;
    tick();
  endtask
  task automatic press_inc();
    bus.increment = 1'b1;
    tick();
    bus.increment = 1'b0;
    tick();
  endtask
  initial begin
    rst_n = 1'b0;
    bus.mode = 1'b1;
    bus.increment = 1'b0;
    bus.cur_hours = 8'd10;
    bus.cur_minutes = 8'd20;
    bus.cur_seconds = 8'd30;
    repeat (3) tick();
    chk("rst_run_en", bus.run_en, 1);
    chk("rst_load", bus.load, 0);
    chk("rst_field", bus.edit_field, 0);
    chk("rst_hours", bus.load_hours, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("held_mode_field", bus.edit_field, 0);
    chk("held_mode_run_en", bus.run_en, 1);
    bus.mode = 1'b0;
    tick();
    // full edit 10:20:30 -> 13:00:01
    bus.mode = 1'b1;
    tick();
    chk("enter_field", bus.edit_field, 1);
    chk("enter_run_en", bus.run_en, 0);
    chk("capture_hours", bus.load_hours, 10);
    bus.mode = 1'b0;
    tick();
    repeat (3) press_inc();
    chk("hours_13", bus.load_hours, 13);
    press_mode();
    chk("field_min", bus.edit_field, 2);
    repeat (40) press_inc();
    chk("minutes_wrap", bus.load_minutes, 0);
    chk("hours_kept", bus.load_hours, 13);
    press_mode();
    chk("field_sec", bus.edit_field, 3);
    repeat (31) press_inc();
    chk("seconds_1", bus.load_seconds, 1);
    bus.mode = 1'b1;
    tick();
    chk("commit_load", bus.load, 1);
    chk("commit_run_en", bus.run_en, 0);
    chk("commit_field", bus.edit_field, 0);
    chk("commit_hours", bus.load_hours, 13);
    chk("commit_minutes", bus.load_minutes, 0);
    chk("commit_seconds", bus.load_seconds, 1);
    bus.mode = 1'b0;
    tick();
    chk("post_load", bus.load, 0);
    chk("post_run_en", bus.run_en, 1);
    chk("load_count_1", load_cnt, 1);
    // auto-repeat from hours = 23
    bus.cur_hours = 8'd23;
    press_mode();
    chk("rep_field", bus.edit_field, 1);
    bus.increment = 1'b1;
    tick();
    chk("rep_edge", bus.load_hours, 0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("rep_hold_%0d", j), bus.load_hours, (j >= 8) + (j >= 10) + (j >= 12));
    end
    bus.increment = 1'b0;
    tick();
    chk("rep_release", bus.load_hours, 3);
    press_mode();
    chk("rep_min_field", bus.edit_field, 2);
    // simultaneous MODE and INCREMENT in SET_MIN
    bus.mode = 1'b1;
    bus.increment = 1'b1;
    tick();
    chk("simul_field", bus.edit_field, 3);
    chk("simul_minutes", bus.load_minutes, 20);
    bus.mode = 1'b0;
    bus.increment = 1'b0;
    tick();
    press_mode();
    chk("load_count_2", load_cnt, 2);
    chk("back_run", bus.run_en, 1);
    // inactivity timeout
    press_mode();
    press_inc();
    saved = load_cnt;
    repeat (44) tick();
    chk("to_still_edit", bus.edit_field, 1);
    repeat (5) tick();
    chk("to_run_en", bus.run_en, 1);
    chk("to_field", bus.edit_field, 0);
    chk("to_no_load", load_cnt, saved);
    // reset mid-edit
    repeat (3) press_mode();
    chk("mid_field", bus.edit_field, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_run_en", bus.run_en, 1);
    chk("mid_rst_load", bus.load, 0);
    chk("mid_rst_field", bus.edit_field, 0);
    chk("mid_rst_hours", bus.load_hours, 0);
    chk("mid_rst_seconds", bus.load_seconds, 0);
    tick();
    chk("mid_rst_stay", bus.edit_field, 0);
    chk("mid_rst_no_load", load_cnt, saved);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Time-setting sequencer for the timekeeping datapath (seconds/minutes/hours counters). It edge-detects the MODE and INCREMENT buttons and walks an edit FSM through hours, minutes and seconds. While editing it holds the timekeeper stopped and edits shadow copies of the time, with auto-repeat on a held INCREMENT. It then issues a single-cycle parallel load back into the timekeeper, or abandons the edit on reset or inactivity timeout.

## Interface
- CLOCK_FREQ, 50000000, system clock frequency in Hz; scales the timing defaults below.
- REPEAT_DELAY, CLOCK_FREQ/2, cycles INCREMENT must be held before the first auto-repeat.
- REPEAT_RATE, CLOCK_FREQ/8, cycles between subsequent auto-repeats.
- EDIT_TIMEOUT, CLOCK_FREQ*10, idle cycles in any SET state before the edit is abandoned.
- CLK  in  1  system clock; the only clock, all logic on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- MODE  in  1  debounced, synchronized button level, active-high.
- INCREMENT  in  1  debounced, synchronized button level, active-high.
- CUR_SECONDS / CUR_MINUTES / CUR_HOURS  in  8 each  live time from the timekeeper.
- run_en  out  1  1 = timekeeper may count; 0 = timekeeper frozen.
- load  out  1  one-cycle strobe: timekeeper loads load_* and clears its sub-second counter.
- load_seconds / load_minutes / load_hours  out  8 each  shadow time, valid while load=1.
- edit_field  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds (display blink select).

## Operation
- Edge detect: a registered previous level per button; edge = level & ~prev. Prev registers reset to 1, so a button held through reset gives no edge until it is released and pressed again.
- States: RUN, SET_HR, SET_MIN, SET_SEC, COMMIT. edit_field is 0 in RUN and COMMIT, and 1/2/3 in SET_HR/SET_MIN/SET_SEC.
- RUN: run_en=1. A MODE edge does three things:
  - captures CUR_* into the shadow registers;
  - moves to SET_HR;
  - drives run_en to 0.
- SET_x, MODE edge: advances SET_HR -> SET_MIN -> SET_SEC -> COMMIT.
- SET_x, INCREMENT edge: adds 1 to the active shadow field.
  - Hours wrap 23->0; minutes and seconds wrap 59->0.
  - Any captured value at or above its limit (hours >= 23, min/sec >= 59) becomes 0 on its next increment.
  - 8-bit arithmetic; the other fields are untouched.
- Auto-repeat: a hold counter clears on each INCREMENT edge and counts while INCREMENT stays high.
  - The first repeat increment comes REPEAT_DELAY cycles after the edge, then one every REPEAT_RATE cycles.
  - Release clears the counter. A MODE edge or state change also clears it; repeat does not carry into the next field.
- Simultaneous MODE and INCREMENT edges: MODE wins and the increment is discarded. A MODE edge also cancels any auto-repeat falling in the same cycle.
- Timeout: the idle counter clears on entry to SET_HR and on every MODE edge, INCREMENT edge or repeat increment.
  - At EDIT_TIMEOUT idle cycles the FSM returns to RUN with run_en=1.
  - No load is issued and the shadow values are discarded.
- COMMIT: lasts exactly one cycle with load=1, then goes to RUN.
- Reset (any time, including mid-edit):
  - state RUN, run_en=1, load=0, edit_field=0;
  - shadows, load_* and all counters cleared to 0;
  - any edit in progress is abandoned without a load.
- INCREMENT in RUN is ignored; the timekeeper's own INCREMENT path is not driven by this block.

## Timing
- All outputs are registered. load_* are driven directly from the shadow registers.
- MODE edge sampled at posedge k in RUN:
  - shadow = CUR_* as presented at edge k;
  - from edge k: state SET_HR, run_en=0, edit_field=1.
- INCREMENT edge at posedge k: updated shadow is visible on load_* after edge k, so latency is 1 cycle.
- Held INCREMENT with its edge at k: repeat increments at k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_RATE, and so on.
- MODE edge at posedge k in SET_SEC:
  - after edge k: load=1, state COMMIT;
  - after edge k+1: load=0, run_en=1, state RUN;
  - the timekeeper loads at edge k+1 and counts from k+2.
- Timeout at posedge k: run_en=1 and edit_field=0 after edge k; load stays 0.
- A MODE edge is accepted in the cycle immediately after COMMIT; a new edit may start at k+2.

## Test plan
- Bench parameters for all scenarios: REPEAT_DELAY=8, REPEAT_RATE=2, EDIT_TIMEOUT=50.
- Reset with MODE held high, then release RST -> run_en=1, load=0, edit_field=0, no state change until MODE is released and pressed again.
- CUR=10:20:30; MODE, INC×3, MODE, INC×40, MODE, INC×31, MODE -> one load pulse with load_hours=13, load_minutes=0, load_seconds=1; run_en returns to 1 the cycle after load.
- CUR hours=23, in SET_HR; hold INCREMENT 13 cycles from its edge -> increments at edge, +8, +10, +12; hours go 0,1,2,3.
- In SET_MIN, MODE and INCREMENT rise in the same cycle -> edit_field becomes 3, minutes unchanged.
- Enter SET_HR, increment once, then 50 idle cycles -> returns to RUN, run_en=1, load never asserted.
- Assert RST for one cycle in SET_SEC -> RUN with all outputs at reset values, no load.
